// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one iterative fp divider among NUM_REQ requesters,
// holding operands for the whole divide and answering with a flagged qNaN on watchdog expiry.
module fp_div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [31:0]             resp_r,
    output logic                    resp_err,
    output logic                    div_start,
    output logic [31:0]             div_a,
    output logic [31:0]             div_b,
    input  logic                    div_done,
    input  logic [31:0]             div_r,
    output logic                    busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Timeout fires when the counter is about to step onto TIMEOUT-1, so the
    // abort response lands TIMEOUT cycles after div_start.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    logic [1:0]         state_r;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      owner_r;
    logic [CW-1:0]      cnt_r;
    logic [NUM_REQ-1:0] resp_valid_r;
    logic [31:0]        resp_r_r;
    logic               resp_err_r;
    logic               div_start_r;
    logic [31:0]        div_a_r;
    logic [31:0]        div_b_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]      gidx_s;
    logic               found_s;
    logic [NUM_REQ-1:0] owner_oh_s;
    logic [31:0]        a_arr_s [NUM_REQ];
    logic [31:0]        b_arr_s [NUM_REQ];

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr_s[i] = req_a[32*i +: 32];
            b_arr_s[i] = req_b[32*i +: 32];
        end
    end

    // Round-robin scan: first valid requester at or above the pointer, wrapping.
    always_comb begin : grant_scan
        int  idx;
        logic hit;
        gidx_s  = '0;
        found_s = 1'b0;
        grant_s = '0;
        idx     = 0;
        hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx     = (int'(ptr_r) + k >= NUM_REQ) ? int'(ptr_r) + k - NUM_REQ : int'(ptr_r) + k;
            hit     = !found_s && req_valid[IW'(idx)];
            gidx_s  = hit ? IW'(idx) : gidx_s;
            found_s = found_s | hit;
        end
        if (found_s) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // One-hot decode of the current owner for the response strobe.
    always_comb begin
        owner_oh_s          = '0;
        owner_oh_s[owner_r] = 1'b1;
    end

    // Main control FSM; all outputs except req_ready are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            owner_r      <= '0;
            cnt_r        <= '0;
            resp_valid_r <= '0;
            resp_r_r     <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            div_start_r  <= 1'b0;
            div_a_r      <= 32'h0000_0000;
            div_b_r      <= 32'h0000_0000;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        div_a_r     <= a_arr_s[gidx_s];
                        div_b_r     <= b_arr_s[gidx_s];
                        owner_r     <= gidx_s;
                        ptr_r       <= (gidx_s == IW'(NUM_REQ - 1)) ? '0 : gidx_s + IW'(1);
                        div_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    div_start_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        resp_r_r     <= div_r;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= owner_oh_s;
                        state_r      <= RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        resp_r_r     <= QNAN;
                        resp_err_r   <= 1'b1;
                        resp_valid_r <= owner_oh_s;
                        state_r      <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready[owner_r]) begin
                        resp_valid_r <= '0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    resp_valid_r <= '0;
                    div_start_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == IDLE) ? grant_s : '0;
    assign resp_valid = resp_valid_r;
    assign resp_r     = resp_r_r;
    assign resp_err   = resp_err_r;
    assign div_start  = div_start_r;
    assign div_a      = div_a_r;
    assign div_b      = div_b_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed vectors and corner sequences for fp_div_arbiter with a
// fixed-latency divider stand-in that can also be told never to finish.
module tb_fp_div_arbiter;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [32*NR-1:0] req_a = '0;
    logic [32*NR-1:0] req_b = '0;
    logic [NR-1:0]   resp_valid;
    logic [NR-1:0]   resp_ready = '0;
    logic [31:0]     resp_r;
    logic            resp_err;
    logic            div_start;
    logic [31:0]     div_a;
    logic [31:0]     div_b;
    logic            div_done;
    logic [31:0]     div_r;
    logic            busy;

    logic            model_done = 1'b0;
    logic            stray_done = 1'b0;
    logic            model_never = 1'b0;
    int              model_lat = 4;
    int              mcnt = 0;
    logic [31:0]     mres = '0;

    int total = 0;
    int bad = 0;

    fp_div_arbiter #(.NUM_REQ(NR), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_r(resp_r), .resp_err(resp_err),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_r(div_r), .busy(busy)
    );

    always #5 clk = ~clk;

    // Quotients of the operands used by this bench (B is always 2.0).
    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        if (b != 32'h4000_0000) return a ^ b;
        case (a)
            32'h3F80_0000: return 32'h3F00_0000;
            32'h4000_0000: return 32'h3F80_0000;
            32'h4040_0000: return 32'h3FC0_0000;
            32'h4080_0000: return 32'h4000_0000;
            32'h40C0_0000: return 32'h4040_0000;
            default:       return a ^ b;
        endcase
    endfunction

    // Divider stand-in: strobes done model_lat cycles after the start pulse.
    always @(negedge clk) begin
        if (reset) begin
            mcnt       <= 0;
            model_done <= 1'b0;
        end else if (div_start && !model_never) begin
            mcnt       <= model_lat;
            model_done <= 1'b0;
            mres       <= quot(div_a, div_b);
        end else if (mcnt > 0) begin
            mcnt       <= mcnt - 1;
            model_done <= (mcnt == 1);
        end else begin
            model_done <= 1'b0;
        end
    end

    assign div_done = model_done | stray_done;
    assign div_r    = mres;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_valid == '0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic [NR-1:0] exp_gnt;
        logic [31:0]   exp_q;
    } vec_t;

    vec_t tbl [9];
    logic early;

    initial begin
        tbl[0] = '{4'hF, 4'b0001, 32'h3F00_0000};
        tbl[1] = '{4'hF, 4'b0010, 32'h3F80_0000};
        tbl[2] = '{4'hF, 4'b0100, 32'h3FC0_0000};
        tbl[3] = '{4'hF, 4'b1000, 32'h4000_0000};
        tbl[4] = '{4'hF, 4'b0001, 32'h3F00_0000};
        tbl[5] = '{4'hF, 4'b0010, 32'h3F80_0000};
        tbl[6] = '{4'hF, 4'b0100, 32'h3FC0_0000};
        tbl[7] = '{4'hA, 4'b1000, 32'h4000_0000};
        tbl[8] = '{4'hA, 4'b0010, 32'h3F80_0000};

        req_a = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        req_b = {4{32'h4000_0000}};

        // Reset state and single request with L=4.
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {22'd0, req_ready, resp_valid, resp_err, div_start}, 32'd0);
        chk("rst_resp_r", resp_r, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        req_a[31:0] = 32'h40C0_0000;
        req_valid = 4'b0001;
        #1;
        chk("s_ready_T", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        req_a[31:0] = 32'h3F80_0000;
        chk("s_start_T1", {31'd0, div_start}, 32'd1);
        chk("s_busy_T1", {31'd0, busy}, 32'd1);
        chk("s_ready_T1", {28'd0, req_ready}, 32'd0);
        chk("s_div_a", div_a, 32'h40C0_0000);
        chk("s_div_b", div_b, 32'h4000_0000);
        tick();
        chk("s_start_T2", {31'd0, div_start}, 32'd0);
        tick(); tick(); tick();
        chk("s_noresp_T5", {28'd0, resp_valid}, 32'd0);
        tick();
        chk("s_resp_T6", {28'd0, resp_valid}, 32'h1);
        chk("s_resp_r", resp_r, 32'h4040_0000);
        chk("s_resp_err", {31'd0, resp_err}, 32'd0);
        resp_ready = 4'hF;
        tick();
        chk("s_resp_clr", {28'd0, resp_valid}, 32'd0);
        chk("s_idle_busy", {31'd0, busy}, 32'd0);

        // Round robin, each requester gets its own quotient, then pointer wrap.
        do_reset();
        resp_ready = 4'hF;
        for (int v = 0; v < 9; v++) begin
            tick();
            req_valid = tbl[v].mask;
            #1;
            wait_grant();
            chk($sformatf("rr_gnt%0d", v), {28'd0, req_ready}, {28'd0, tbl[v].exp_gnt});
            tick();
            wait_resp();
            chk($sformatf("rr_own%0d", v), {28'd0, resp_valid}, {28'd0, tbl[v].exp_gnt});
            chk($sformatf("rr_q%0d", v), resp_r, tbl[v].exp_q);
        end
        req_valid = '0;

        // Backpressure: requester 1 holds off while requester 0 waits.
        do_reset();
        resp_ready = '0;
        tick();
        req_valid = 4'b0010;
        #1;
        chk("bp_gnt1", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'b0001;
        wait_resp();
        chk("bp_resp1", {28'd0, resp_valid}, 32'h2);
        chk("bp_q1", resp_r, 32'h3F80_0000);
        resp_ready = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp_hold_v%0d", c), {28'd0, resp_valid}, 32'h2);
            chk($sformatf("bp_hold_r%0d", c), resp_r, 32'h3F80_0000);
            chk($sformatf("bp_hold_g%0d", c), {28'd0, req_ready}, 32'd0);
        end
        resp_ready = 4'hF;
        #1;
        chk("bp_hs_g", {28'd0, req_ready}, 32'd0);
        tick();
        chk("bp_after_v", {28'd0, resp_valid}, 32'd0);
        chk("bp_after_g", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        wait_resp();
        chk("bp_resp0", {28'd0, resp_valid}, 32'h1);
        chk("bp_q0", resp_r, 32'h3F00_0000);

        // Timeout: divider never finishes.
        do_reset();
        model_never = 1'b1;
        resp_ready = '0;
        tick();
        req_valid = 4'b0100;
        #1;
        chk("to_gnt", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        chk("to_start", {31'd0, div_start}, 32'd1);
        early = 1'b0;
        for (int k = 1; k < 64; k++) begin
            tick();
            if (resp_valid != '0) early = 1'b1;
        end
        chk("to_early", {31'd0, early}, 32'd0);
        tick();
        chk("to_valid", {28'd0, resp_valid}, 32'h4);
        chk("to_r", resp_r, 32'h7FC0_0000);
        chk("to_err", {31'd0, resp_err}, 32'd1);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("to_late_r", resp_r, 32'h7FC0_0000);
        chk("to_late_err", {31'd0, resp_err}, 32'd1);
        chk("to_late_v", {28'd0, resp_valid}, 32'h4);
        resp_ready = 4'hF;
        tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("to_stray_busy", {31'd0, busy}, 32'd0);
        chk("to_stray_v", {28'd0, resp_valid}, 32'd0);
        chk("to_stray_r", resp_r, 32'h7FC0_0000);

        // Done arriving on the timeout cycle wins.
        do_reset();
        model_never = 1'b0;
        model_lat = 63;
        resp_ready = '0;
        tick();
        req_valid = 4'b0001;
        #1;
        chk("tie_gnt", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        early = 1'b0;
        for (int k = 1; k < 64; k++) begin
            tick();
            if (resp_valid != '0) early = 1'b1;
        end
        chk("tie_early", {31'd0, early}, 32'd0);
        tick();
        chk("tie_valid", {28'd0, resp_valid}, 32'h1);
        chk("tie_r", resp_r, 32'h3F00_0000);
        chk("tie_err", {31'd0, resp_err}, 32'd0);
        resp_ready = 4'hF;
        tick();
        model_lat = 4;

        // Reset during WAIT, then a stray done.
        do_reset();
        model_never = 1'b1;
        tick();
        req_valid = 4'b0010;
        #1;
        chk("rw_gnt", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_outs", {22'd0, req_ready, resp_valid, resp_err, div_start}, 32'd0);
        chk("rw_resp_r", resp_r, 32'd0);
        chk("rw_div_a", div_a, 32'd0);
        chk("rw_div_b", div_b, 32'd0);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (resp_valid != '0 || busy) early = 1'b1;
        end
        chk("rw_no_resp", {31'd0, early}, 32'd0);
        model_never = 1'b0;
        req_valid = 4'b0110;
        #1;
        chk("rw_ptr0", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        wait_resp();
        chk("rw_resp", {28'd0, resp_valid}, 32'h2);
        chk("rw_q", resp_r, 32'h3F80_0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
- Shares one iterative fp_div unit (start pulse in, done strobe out) among NUM_REQ independent requesters.
- Round-robin arbitration, valid/ready request and response handshakes, and operand holding for the full divide.
- Watchdog timeout returns a flagged qNaN if the divider never strobes done.
- Sits between the FPU issue logic and the divider instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles from div_start to div_done before abort (>= divider latency + 2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester divide request
req_ready  out  NUM_REQ  one-hot accept; asserted only for the granted requester in IDLE
req_a  in  32*NUM_REQ  dividend per requester, slice i = [32*i+31:32*i]
req_b  in  32*NUM_REQ  divisor per requester, same slicing
resp_valid  out  NUM_REQ  one-hot result valid to owning requester
resp_ready  in  NUM_REQ  per-requester result accept
resp_r  out  32  result, shared bus, meaningful only with a resp_valid bit set
resp_err  out  1  result came from timeout abort; qualified by resp_valid
div_start  out  1  one-cycle start pulse to divider
div_a  out  32  dividend to divider, held stable ISSUE through WAIT
div_b  out  32  divisor to divider, held stable ISSUE through WAIT
div_done  in  1  divider result strobe
div_r  in  32  divider result, sampled on div_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - All outputs are 0: req_ready, resp_valid, resp_r, resp_err, div_start, div_a, div_b, busy.
  - State is IDLE, the round-robin pointer is 0 and the timeout counter is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning from pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g] is combinational high in the same cycle.
  - Latch req_a[g] and req_b[g] into div_a and div_b, latch owner=g, set pointer=(g+1) mod NUM_REQ, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: div_start=1 for exactly this cycle. Clear the counter, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_done: latch div_r into resp_r, set resp_err=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without div_done: resp_r=32'h7FC00000, resp_err=1, go to RESP.
  - If div_done arrives on the same cycle as the timeout, div_done wins.
- RESP:
  - resp_valid[owner]=1; resp_r and resp_err are held stable.
  - On resp_ready[owner]: clear resp_valid and go to IDLE.
  - resp_ready of any other requester is ignored.
- Holding: div_a and div_b only change in IDLE on a grant. A requester may drop req_valid after acceptance without effect.
- div_done outside WAIT is ignored; no state change and resp_r is untouched.
- Only one divide is in flight; no request is accepted between grant and response handshake.
- Latency:
  - Accept at cycle T, div_start at T+1.
  - If the divider strobes done at T+1+L, resp_valid rises at T+2+L.
  - Minimum accept-to-accept spacing is L+3 cycles with resp_ready tied high.
- Reset asserted in any state:
  - Next edge returns to IDLE and drops any pending response without a handshake; pointer goes to 0.
  - A div_done arriving after reset is ignored.
- Result bits are not modified; IEEE handling stays inside the divider.

Test Plan:
- Single request, divider model with L=4: req 0 sends A=0x40C00000 (6.0), B=0x40000000 (2.0), and the model returns 0x40400000 at start+4 -> req_ready[0] at T, div_start at T+1, resp_valid[0] at T+6 with resp_r=0x40400000, resp_err=0.
- All four requesters valid continuously, resp_ready high -> grant order 0,1,2,3,0,1; each requester receives its own quotient (requester i sends A=i+1.0, B=2.0); exactly one req_ready bit per grant.
- Pointer wrap: after req 2 completes, only req 1 and req 3 are valid -> req 3 is granted first, then req 1.
- Backpressure: hold resp_ready[1]=0 for 10 cycles in RESP while req 0 is valid -> resp_valid[1] and resp_r stay stable, req_ready[0] stays 0 until the handshake, and req 0 is granted the cycle after IDLE re-entry.
- Timeout: the divider model never strobes done, TIMEOUT=64 -> resp_valid[owner] 64 cycles after div_start with resp_r=0x7FC00000, resp_err=1; a late div_done is ignored.
- Reset in WAIT, then a stray div_done -> busy=0 and all outputs 0 the cycle after reset; no resp_valid is produced; the next request is granted from requester 0 upward.
